// File: rtl/stream_xbar_pkg.sv
// Shared definitions for the stream crossbar weighted round-robin scheduler.
package stream_xbar_pkg;

    localparam int unsigned DefWeightWidth = 4;

    // A programmed weight of zero behaves like one so an input can never be starved.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

    // Successor index with wrap, valid for any input count.
    function automatic int unsigned next_idx(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/stream_xbar_wrr_chan.sv
// Per-output pointer and credit tracking for the weighted round-robin scheduler.
module stream_xbar_wrr_chan
    import stream_xbar_pkg::*;
#(
    parameter int unsigned NumInp      = 1,
    parameter int unsigned WeightWidth = DefWeightWidth,
    parameter int unsigned IdxWidth    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   hs_i,
    input  logic [IdxWidth-1:0]    src_i,
    input  logic [WeightWidth-1:0] src_weight_i,
    output logic [IdxWidth-1:0]    rr_o
);

    logic [IdxWidth-1:0]    rr_q, rr_d;
    logic [WeightWidth-1:0] cnt_q, cnt_d;

    int unsigned weff;
    int unsigned cnt_inc;
    logic [IdxWidth-1:0] nxt_idx;
    logic src_valid;
    logic hs;
    logic own;

    assign weff      = eff_weight(32'(src_weight_i));
    assign cnt_inc   = 32'(cnt_q) + 1;
    assign nxt_idx   = IdxWidth'(next_idx(32'(src_i), NumInp));
    assign src_valid = 32'(src_i) < NumInp;
    assign hs        = hs_i && src_valid;
    assign own       = (src_i == rr_q);

    // Next pointer/credit: flush wins over a handshake; no handshake holds state.
    always_comb begin
        rr_d  = rr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rr_d  = '0;
            cnt_d = '0;
        end else if (hs) begin
            if (own) begin
                // >= lets a weight lowered mid-burst close the burst right away.
                if (cnt_inc >= weff) begin
                    rr_d  = nxt_idx;
                    cnt_d = '0;
                end else begin
                    cnt_d = WeightWidth'(cnt_inc);
                end
            end else if (weff == 1) begin
                // Owner was idle and the winner's single-beat burst is already done.
                rr_d  = nxt_idx;
                cnt_d = '0;
            end else begin
                // Winner takes ownership with its first beat already counted.
                rr_d  = src_i;
                cnt_d = WeightWidth'(1);
            end
        end
    end

    // Pointer and credit registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign rr_o = rr_q;

endmodule

// File: rtl/stream_xbar_wrr_sched.sv
// Weighted round-robin priority scheduler feeding a crossbar's external rr_i input.
module stream_xbar_wrr_sched
    import stream_xbar_pkg::*;
#(
    parameter int          NumInp      = 0,
    parameter int          NumOut      = 0,
    parameter int unsigned WeightWidth = DefWeightWidth,
    localparam int unsigned IdxWidth   = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [IdxWidth-1:0]        cfg_idx_i,
    input  logic [WeightWidth-1:0]     cfg_weight_i,
    input  logic [NumOut-1:0]          xbar_valid_i,
    input  logic [NumOut-1:0]          xbar_ready_i,
    input  logic [NumOut*IdxWidth-1:0] xbar_idx_i,
    output logic [NumOut*IdxWidth-1:0] rr_o
);

    // Keeps storage sizing sane if the block is elaborated with the unset defaults.
    localparam int unsigned NumInpU = (NumInp > 0) ? NumInp : 1;

    logic [WeightWidth-1:0] weight_q [NumInpU];
    logic [WeightWidth-1:0] weight_d [NumInpU];
    logic                   cfg_hit;

    assign cfg_ready_o = ~rst_i;
    assign cfg_hit     = cfg_valid_i && cfg_ready_o && (32'(cfg_idx_i) < NumInpU);

    // Weight write; out-of-range indices are accepted but dropped.
    always_comb begin
        weight_d = weight_q;
        if (cfg_hit) begin
            weight_d[cfg_idx_i] = cfg_weight_i;
        end
    end

    // Weight registers; flush leaves them alone, reset restores weight one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumInpU); i++) begin
                weight_q[i] <= WeightWidth'(1);
            end
        end else begin
            weight_q <= weight_d;
        end
    end

    for (genvar j = 0; j < NumOut; j++) begin : g_chan
        logic [IdxWidth-1:0]    src;
        logic [WeightWidth-1:0] src_weight;
        logic                   hs;

        assign src = xbar_idx_i[j*IdxWidth +: IdxWidth];
        assign hs  = xbar_valid_i[j] && xbar_ready_i[j];
        // Registered weight, so a write landing this cycle only affects later beats.
        assign src_weight = (32'(src) < NumInpU) ? weight_q[src] : WeightWidth'(1);

        stream_xbar_wrr_chan #(
            .NumInp      (NumInpU),
            .WeightWidth (WeightWidth),
            .IdxWidth    (IdxWidth)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .flush_i      (flush_i),
            .hs_i         (hs),
            .src_i        (src),
            .src_weight_i (src_weight),
            .rr_o         (rr_o[j*IdxWidth +: IdxWidth])
        );
    end

endmodule

// File: tb/tb_stream_xbar_wrr_sched.sv
// Directed bench for the weighted round-robin scheduler with a reference-model scoreboard.
module tb_stream_xbar_wrr_sched;

    localparam int NI = 3;
    localparam int NO = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_idx = '0;
    logic [3:0] cfg_weight = '0;
    logic [1:0] xv = '0;
    logic [1:0] xr = '0;
    logic [3:0] xidx = '0;
    logic [3:0] rr;

    int n_run  = 0;
    int n_fail = 0;

    int mw [NI];
    int mrr [NO];
    int mcnt [NO];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    stream_xbar_wrr_sched #(
        .NumInp      (NI),
        .NumOut      (NO),
        .WeightWidth (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_idx_i    (cfg_idx),
        .cfg_weight_i (cfg_weight),
        .xbar_valid_i (xv),
        .xbar_ready_i (xr),
        .xbar_idx_i   (xidx),
        .rr_o         (rr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Crossbar with external priority: first requester at or after the start index.
    function automatic int pick(input logic [2:0] mask, input int start);
        for (int i = 0; i < NI; i++) begin
            if (mask[(start + i) % NI]) return (start + i) % NI;
        end
        return 0;
    endfunction

    // One cycle: drive, update the model, queue the expected rr, compare after the edge.
    task automatic step(input logic [1:0] v, input logic [1:0] r, input int i0, input int i1,
                        input logic cv, input int ci, input int cw, input logic fl,
                        input logic rs, input string tag);
        int idx, we;
        xv = v; xr = r; xidx = {2'(i1), 2'(i0)};
        cfg_valid = cv; cfg_idx = 2'(ci); cfg_weight = 4'(cw);
        flush = fl; rst = rs;
        #1;
        chk({tag, ":cfg_ready"}, 32'(cfg_ready), 32'(!rs));
        if (rs) begin
            for (int i = 0; i < NI; i++) mw[i] = 1;
            for (int j = 0; j < NO; j++) begin mrr[j] = 0; mcnt[j] = 0; end
        end else begin
            for (int j = 0; j < NO; j++) begin
                idx = (j == 0) ? i0 : i1;
                if (fl) begin
                    mrr[j] = 0; mcnt[j] = 0;
                end else if (v[j] && r[j] && idx < NI) begin
                    we = (mw[idx] == 0) ? 1 : mw[idx];
                    if (idx == mrr[j]) begin
                        if (mcnt[j] + 1 >= we) begin
                            mrr[j] = (idx + 1) % NI; mcnt[j] = 0;
                        end else begin
                            mcnt[j] = mcnt[j] + 1;
                        end
                    end else if (we == 1) begin
                        mrr[j] = (idx + 1) % NI; mcnt[j] = 0;
                    end else begin
                        mrr[j] = idx; mcnt[j] = 1;
                    end
                end
            end
            if (cv && ci < NI) mw[ci] = cw;
        end
        exp_q.push_back({2'(mrr[1]), 2'(mrr[0])});
        @(posedge clk);
        #1;
        chk({tag, ":rr"}, 32'(rr), 32'(exp_q.pop_front()));
    endtask

    task automatic idle(input string tag);
        step(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    task automatic cfg(input int ci, input int cw, input string tag);
        step(2'b00, 2'b00, 0, 0, 1'b1, ci, cw, 1'b0, 1'b0, tag);
    endtask

    task automatic beat(input int j, input int src, input string tag);
        if (j == 0) step(2'b01, 2'b01, src, 0, 1'b0, 0, 0, 1'b0, 1'b0, tag);
        else        step(2'b10, 2'b10, 0, src, 1'b0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq [8] = '{0, 0, 1, 2, 2, 2, 0, 0};
        int src;
        @(posedge clk);
        #1;

        step(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1, "reset0");
        step(2'b11, 2'b11, 1, 2, 1'b1, 1, 9, 1'b1, 1'b1, "reset1");
        chk("reset_rr_zero", 32'(rr), 32'h0);

        cfg(0, 2, "cfg_w0");
        cfg(1, 1, "cfg_w1");
        cfg(2, 3, "cfg_w2");
        cfg(3, 7, "cfg_oob");

        // All inputs streaming on out0; out1 sees random sources including out-of-range.
        for (int i = 0; i < 8; i++) begin
            src = pick(3'b111, int'(rr[1:0]));
            chk($sformatf("stream_src%0d", i), 32'(src), 32'(seq[i]));
            step(2'b11, 2'b11, src, int'($urandom_range(0, 3)), 1'b0, 0, 0, 1'b0, 1'b0,
                 $sformatf("stream%0d", i));
        end
        chk("stream_end_rr", 32'(rr[1:0]), 32'd1);

        // Weight lowered mid-burst closes the burst on the next beat.
        beat(0, 1, "to_rr2");
        chk("at_rr2", 32'(rr[1:0]), 32'd2);
        beat(0, 2, "b2_first");
        cfg(2, 1, "lower_w2");
        beat(0, 2, "b2_second");
        chk("lowered_end", 32'(rr[1:0]), 32'd0);

        // Write coinciding with a beat from the same input uses the old weight.
        beat(0, 0, "w0_a");
        beat(0, 0, "w0_b");
        beat(0, 1, "w1_a");
        step(2'b01, 2'b01, 2, 0, 1'b1, 2, 3, 1'b0, 1'b0, "coincide");
        chk("coincide_old_w", 32'(rr[1:0]), 32'd0);
        beat(0, 2, "new_w2");
        chk("new_w2_rr", 32'(rr[1:0]), 32'd2);

        // Lone requester on out1 takes ownership from an idle pointer.
        step(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, "flush_a");
        cfg(1, 2, "w1_two");
        beat(1, 1, "lone_a");
        chk("lone_a_rr", 32'(rr[3:2]), 32'd1);
        beat(1, 1, "lone_b");
        chk("lone_b_rr", 32'(rr[3:2]), 32'd2);

        // Flush with a simultaneous handshake mid-burst.
        beat(1, 2, "pre_flush");
        chk("pre_flush_rr", 32'(rr[3:2]), 32'd2);
        step(2'b10, 2'b10, 0, 2, 1'b0, 0, 0, 1'b1, 1'b0, "flush_hs");
        chk("flush_rr", 32'(rr), 32'h0);
        beat(1, 2, "post_flush_a");
        chk("w2_kept", 32'(rr[3:2]), 32'd2);
        beat(1, 2, "post_flush_b");
        beat(1, 2, "post_flush_c");
        chk("burst3_wrap", 32'(rr[3:2]), 32'd0);

        // Out-of-range source is ignored; zero weight acts as one.
        beat(0, 3, "oob_src");
        chk("oob_src_rr", 32'(rr[1:0]), 32'd0);
        cfg(0, 0, "w0_zero");
        beat(0, 0, "w0_zero_beat");
        chk("w0_zero_rr", 32'(rr[1:0]), 32'd1);

        // Reset mid-burst abandons the burst and restores weight one.
        beat(0, 1, "burst_w1");
        step(2'b01, 2'b01, 1, 0, 1'b1, 1, 5, 1'b0, 1'b1, "mid_reset");
        chk("mid_reset_rr", 32'(rr), 32'h0);
        beat(0, 2, "after_rst_a");
        chk("after_rst_w2_one", 32'(rr[1:0]), 32'd0);
        beat(0, 1, "after_rst_b");
        chk("after_rst_w1_one", 32'(rr[1:0]), 32'd2);
        idle("tail");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_xbar_wrr_sched.md
STREAM_XBAR_WRR_SCHED -- requirements
Module: stream_xbar_wrr_sched

Interface
REQ-001 SHALL have parameter NumInp, default 0, number of crossbar inputs (>0).
REQ-002 SHALL have parameter NumOut, default 0, number of crossbar outputs (>0).
REQ-003 SHALL have parameter WeightWidth, default 4, width of per-input weight.
REQ-004 SHALL have derived parameter IdxWidth = (NumInp>1) ? clog2(NumInp) : 1; not to be overridden.
REQ-005 SHALL have port clk_i  in  1  clock; the block uses one clock, rising edge.
REQ-006 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port flush_i  in  1  synchronous clear of all pointers and credit counters.
REQ-008 SHALL have port cfg_valid_i  in  1  weight write request.
REQ-009 SHALL have port cfg_ready_o  out  1  weight write accepted.
REQ-010 SHALL have port cfg_idx_i  in  IdxWidth  input index whose weight is written.
REQ-011 SHALL have port cfg_weight_i  in  WeightWidth  new weight value.
REQ-012 SHALL have port xbar_valid_i  in  NumOut  monitored crossbar output valid.
REQ-013 SHALL have port xbar_ready_i  in  NumOut  monitored crossbar output ready.
REQ-014 SHALL have port xbar_idx_i  in  NumOut x IdxWidth  monitored crossbar output source index.
REQ-015 SHALL have port rr_o  out  NumOut x IdxWidth  external priority start, driven to the crossbar rr_i with ExtPrio=1.

Function
REQ-016 SHALL hold one weight register per input, shared by all outputs; effective weight = max(weight,1).
REQ-017 SHALL assert cfg_ready_o whenever rst_i=0; a write with cfg_valid_i&cfg_ready_o updates the weight on the next edge.
REQ-018 SHALL ignore a write with cfg_idx_i >= NumInp (accepted, no effect).
REQ-019 SHALL keep per output j a pointer rr_q[j] and a credit counter cnt_q[j] (WeightWidth bits); rr_o[j] = rr_q[j] (registered, no combinational path from xbar_* to rr_o).
REQ-020 SHALL treat a handshake at output j as xbar_valid_i[j]&xbar_ready_i[j] with source k = xbar_idx_i[j]; no handshake leaves rr_q[j], cnt_q[j] unchanged.
REQ-021 SHALL, on handshake with k==rr_q[j]: if cnt_q[j]+1 >= effective weight[k], set rr_q[j]=next(k), cnt_q[j]=0; else cnt_q[j]+=1.
REQ-022 SHALL, on handshake with k!=rr_q[j] (owner was idle): if effective weight[k]==1, set rr_q[j]=next(k), cnt_q[j]=0; else rr_q[j]=k, cnt_q[j]=1.
REQ-023 SHALL compute next(k)=k+1, wrapping NumInp-1 to 0 for any NumInp, not only powers of two.
REQ-024 SHALL compare credits with >= so a weight lowered mid-burst ends the burst on the next handshake; comparison uses the weight value present in the cycle of the handshake.
REQ-025 SHALL, when a weight write and handshake coincide for the same input, use the old weight for that handshake.
REQ-026 SHALL ignore handshakes with xbar_idx_i[j] >= NumInp (no state change).
REQ-027 SHALL, on flush_i=1, set all rr_q=0 and cnt_q=0 on the next edge, taking priority over handshakes; weights are retained.
REQ-028 SHALL update all NumOut channels independently in the same cycle.

Reset
REQ-029 SHALL, while rst_i=1, set rr_o=0, all cnt_q=0, all weights=1, cfg_ready_o=0, on the rising edge (synchronous).
REQ-030 SHALL take reset priority over flush_i and cfg writes; a burst in progress is abandoned.

Structure
REQ-031 SHALL place WeightWidth default and the effective-weight/next-index functions in the shared package stream_xbar_pkg.
REQ-032 SHALL implement per-output pointer/credit logic in one sub-module stream_xbar_wrr_chan, instantiated NumOut times.

Verification
REQ-033 SHALL cover NumInp=3, NumOut=1, weights {2,1,3}, all inputs streaming, ready=1 -> source sequence 0,0,1,2,2,2,0,0,...
REQ-034 SHALL cover weight write w[2]=1 after first of three input-2 beats -> burst ends after the second beat, rr_o=0.
REQ-035 SHALL cover only input 1 requesting, rr_q=0, w[1]=2 -> after first beat rr_o=1, cnt=1; after second rr_o=2.
REQ-036 SHALL cover rr_q=2 at NumInp=3 end of burst -> rr_o wraps to 0.
REQ-037 SHALL cover flush_i with simultaneous handshake at cnt=1 -> rr_o=0, cnt=0 next cycle, weights unchanged.
REQ-038 SHALL cover rst_i asserted mid-burst -> rr_o=0, weights read back as 1 behaviour, cfg_ready_o=0 during reset.
